// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared opcodes, states and glyph codes for the VGA text path
package vga_pkg;

  typedef enum logic [1:0] {
    OP_APPEND    = 2'd0,
    OP_BACKSPACE = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_NOP       = 2'd3
  } op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] PAT_BLANK  = 8'd0;
  localparam logic [7:0] PAT_SQUARE = 8'd1;
  localparam logic [7:0] PAT_A      = 8'd2;
  localparam logic [7:0] PAT_B      = 8'd3;

  localparam int MAX_WORDS = 31;

endpackage

// File: rtl/word_buffer.sv
// rtl/word_buffer.sv - frame-synchronised glyph buffer feeding the VGA colour stage
// Edits land in a working copy; a frame-start pulse copies it whole to the display copy.
module word_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH  = MAX_WORDS,
  parameter int CODE_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_frame_start,
  output logic [4:0]        o_word_cnt,
  output logic [CODE_W-1:0] o_pattern_num [0:31],
  output logic              o_overflow
);

  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);
  localparam logic [4:0] LAST_IDX  = 5'd31;

  state_t            state, state_nxt;
  op_t               op;
  logic [4:0]        wcnt;
  logic [4:0]        clr_idx;
  logic [CODE_W-1:0] wbuf [0:31];
  logic              commit_pending;
  logic              accept;
  logic              commit;

  assign op     = op_t'(i_op);
  assign accept = i_valid && o_ready;
  // A pulse seen during a clear is honoured on the first idle edge afterwards.
  assign commit = (state == ST_IDLE) && (i_frame_start || commit_pending);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && op == OP_CLEAR) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clr_idx == LAST_IDX)      state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    case (state)
      ST_IDLE:  o_ready = 1'b1;
      ST_CLEAR: o_ready = 1'b0;
      default:  o_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) wbuf[i] <= '0;
      wcnt       <= '0;
      clr_idx    <= '0;
      o_overflow <= 1'b0;
    end else if (state == ST_CLEAR) begin
      wbuf[clr_idx] <= '0;
      clr_idx       <= clr_idx + 5'd1;
    end else if (accept) begin
      case (op)
        OP_APPEND: begin
          if (wcnt < DEPTH_CNT) begin
            wbuf[wcnt] <= i_code;
            wcnt       <= wcnt + 5'd1;
          end else begin
            o_overflow <= 1'b1;
          end
        end
        OP_BACKSPACE: begin
          if (wcnt != 5'd0) begin
            wbuf[wcnt - 5'd1] <= '0;
            wcnt              <= wcnt - 5'd1;
          end
        end
        OP_CLEAR: begin
          wcnt       <= '0;
          o_overflow <= 1'b0;
          clr_idx    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Non-blocking copy means an edit accepted on a commit edge misses this frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) o_pattern_num[i] <= '0;
      o_word_cnt     <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (commit) begin
        o_pattern_num  <= wbuf;
        o_word_cnt     <= wcnt;
        commit_pending <= 1'b0;
      end else if (state == ST_CLEAR && i_frame_start) begin
        commit_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_buffer.sv
// tb/tb_word_buffer.sv - directed self-checking bench for word_buffer
module tb_word_buffer;
  import vga_pkg::*;

  logic       i_clk;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [1:0] i_op;
  logic [7:0] i_code;
  logic       i_frame_start;
  logic [4:0] o_word_cnt;
  logic [7:0] o_pattern_num [0:31];
  logic       o_overflow;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         low_cycles;
  logic [7:0] exp_pat [0:31];

  word_buffer #(.DEPTH(31), .CODE_W(8)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_op          (i_op),
    .i_code        (i_code),
    .i_frame_start (i_frame_start),
    .o_word_cnt    (o_word_cnt),
    .o_pattern_num (o_pattern_num),
    .o_overflow    (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int cnt);
    chk({tag, " word_cnt"}, int'(o_word_cnt), cnt);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s pat[%0d]", tag, i), int'(o_pattern_num[i]), int'(exp_pat[i]));
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 32; i++) exp_pat[i] = 8'd0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req(input op_t op, input logic [7:0] code);
    i_valid = 1'b1;
    i_op    = op;
    i_code  = code;
    tick();
    i_valid = 1'b0;
    i_op    = OP_NOP;
    i_code  = 8'd0;
  endtask

  task automatic frame();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      if (o_ready) break;
      tick();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_op = OP_NOP; i_code = 8'd0; i_frame_start = 1'b0;
    clr_exp();
    tick(); tick();
    i_rst = 1'b0;
    tick();
    chk("reset ready", int'(o_ready), 1);
    chk("reset overflow", int'(o_overflow), 0);
    chk_disp("reset", 0);

    // two appends, invisible until the frame pulse
    req(OP_APPEND, PAT_A);
    req(OP_APPEND, PAT_B);
    chk("pre-commit word_cnt", int'(o_word_cnt), 0);
    chk("pre-commit pat[0]", int'(o_pattern_num[0]), 0);
    frame();
    exp_pat[0] = 8'd2; exp_pat[1] = 8'd3;
    chk_disp("first commit", 2);

    // append then backspace leaves entry 2 blank
    req(OP_APPEND, PAT_B);
    req(OP_BACKSPACE, 8'd0);
    frame();
    chk_disp("backspace", 2);
    chk("backspace overflow", int'(o_overflow), 0);

    // clear with a frame pulse five cycles in: deferred commit
    req(OP_CLEAR, 8'd0);
    low_cycles = 0;
    if (!o_ready) low_cycles++;
    for (int i = 1; i < 60; i++) begin
      i_frame_start = (i == 5);
      tick();
      i_frame_start = 1'b0;
      if (o_ready) break;
      low_cycles++;
    end
    chk("clear ready low cycles", low_cycles, 32);
    chk("clear no early commit", int'(o_word_cnt), 2);
    tick();
    clr_exp();
    chk_disp("deferred commit", 0);

    // backspace on empty buffer
    req(OP_BACKSPACE, 8'd0);
    frame();
    chk("empty backspace word_cnt", int'(o_word_cnt), 0);
    chk("empty backspace overflow", int'(o_overflow), 0);

    // fill to 31, then one dropped append
    for (int i = 0; i < 31; i++) req(OP_APPEND, PAT_A);
    chk("full no overflow yet", int'(o_overflow), 0);
    req(OP_APPEND, PAT_B);
    chk("overflow set", int'(o_overflow), 1);
    frame();
    for (int i = 0; i < 31; i++) exp_pat[i] = 8'd2;
    chk_disp("full commit", 31);
    req(OP_CLEAR, 8'd0);
    chk("clear drops overflow", int'(o_overflow), 0);
    wait_ready();
    chk("ready after clear", int'(o_ready), 1);
    frame();
    clr_exp();
    chk_disp("after overflow clear", 0);

    // edit on the same edge as the frame pulse
    req(OP_APPEND, PAT_A);
    req(OP_APPEND, PAT_A);
    frame();
    chk("same-edge base", int'(o_word_cnt), 2);
    i_valid = 1'b1; i_op = OP_APPEND; i_code = PAT_B; i_frame_start = 1'b1;
    tick();
    i_valid = 1'b0; i_op = OP_NOP; i_code = 8'd0; i_frame_start = 1'b0;
    exp_pat[0] = 8'd2; exp_pat[1] = 8'd2;
    chk_disp("same-edge old", 2);
    frame();
    exp_pat[2] = 8'd3;
    chk_disp("same-edge next", 3);

    req(OP_NOP, 8'd0);
    frame();
    chk_disp("nop", 3);

    // asynchronous reset ten cycles into a clear
    req(OP_CLEAR, 8'd0);
    repeat (10) tick();
    chk("mid-clear ready", int'(o_ready), 0);
    #2 i_rst = 1'b1;
    #1;
    chk("async reset word_cnt", int'(o_word_cnt), 0);
    chk("async reset ready", int'(o_ready), 1);
    tick();
    i_rst = 1'b0;
    tick();
    clr_exp();
    chk("post-reset ready", int'(o_ready), 1);
    chk("post-reset overflow", int'(o_overflow), 0);
    chk_disp("post-reset", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/word_buffer.md
# word_buffer

Frame-synchronised character buffer that sits directly upstream of the VGA colour stage. It accepts recognised glyph codes from the gesture classifier over a valid/ready handshake, supports append, backspace and clear editing, and keeps a working copy of the text. The working copy is committed to a display copy only on a frame-start pulse, so the colour stage never sees a half-edited line mid-frame. The display copy drives the colour stage's word-count and pattern-number inputs.

## Interface
- DEPTH, 31: maximum stored glyphs. Bounded by the 5-bit count.
- CODE_W, 8: glyph code width.

- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request this cycle.
- i_op  in  2  request opcode: OP_APPEND=0, OP_BACKSPACE=1, OP_CLEAR=2, OP_NOP=3.
- i_code  in  CODE_W  glyph code. Used only with OP_APPEND.
- i_frame_start  in  1  one-cycle pulse at start of the vertical blank.
- o_word_cnt  out  5  committed glyph count.
- o_pattern_num  out  [0:31][CODE_W]  committed glyph codes. Entries at or above o_word_cnt are 0.
- o_overflow  out  1  sticky flag: an append was dropped because the buffer was full.

## Operation
- A request is accepted at a rising edge when i_valid && o_ready.
- States:
  - ST_IDLE: o_ready=1.
  - ST_CLEAR: o_ready=0.
- OP_APPEND:
  - If wcnt<DEPTH: wbuf[wcnt]<=i_code and wcnt<=wcnt+1.
  - If wcnt==DEPTH: drop the request and set o_overflow.
- OP_BACKSPACE:
  - If wcnt>0: wbuf[wcnt-1]<=0 and wcnt<=wcnt-1.
  - If wcnt==0: no effect.
- OP_NOP: accepted, no effect.
- OP_CLEAR:
  - wcnt<=0, o_overflow<=0, clear index<=0, go to ST_CLEAR.
  - In ST_CLEAR, one entry is zeroed per cycle: wbuf[idx]<=0, idx<=idx+1.
  - When idx==31, go back to ST_IDLE.
- Commit: dbuf<=wbuf and dcnt<=wcnt as one parallel copy.
  - Happens on an i_frame_start edge while in ST_IDLE, or on the edge following a deferred commit.
- i_frame_start while in ST_CLEAR sets commit_pending.
  - The commit then happens on the first ST_IDLE edge and commit_pending is cleared.
  - Further pulses while pending are merged into the one pending commit.
- o_word_cnt=dcnt and o_pattern_num=dbuf. Both are registered.
- All arithmetic is on 5-bit unsigned values. wcnt never exceeds DEPTH and never wraps.

## Timing
- Reset values:
  - Working and display buffers all 0; wcnt=dcnt=0.
  - o_overflow=0, commit_pending=0, state ST_IDLE.
  - o_ready=1 in the first cycle after i_rst deasserts.
- Reset asserted mid-clear or mid-edit: immediate return to the reset values. Partial edits are lost.
- Edit latency: a request accepted at edge N updates the working copy at edge N. It is visible on the outputs after the first commit edge later than N.
- Accepted edit and i_frame_start at the same edge: the commit copies the pre-edit working copy. The edit reaches the display at the next frame.
- Clear request accepted at edge N:
  - o_ready is low for exactly 32 cycles, edges N+1..N+32.
  - o_ready is high again after edge N+32.
- Outputs change only at commit edges or reset. They are stable for the whole active frame.

## Structure
- Shared package vga_pkg holds:
  - op_t enum (OP_APPEND, OP_BACKSPACE, OP_CLEAR, OP_NOP).
  - state_t enum (ST_IDLE, ST_CLEAR).
  - Glyph codes: PAT_BLANK=0, PAT_SQUARE=1, PAT_A=2, PAT_B=3.
  - MAX_WORDS=31.
- The colour stage imports the same glyph constants from vga_pkg.
- Single module; no sub-module. The working and display copies are plain register arrays, not RAM, because the colour stage reads all entries in parallel.

## Test plan
- Reset, then append PAT_A, PAT_B, then pulse i_frame_start -> o_word_cnt=2, o_pattern_num[0]=2, [1]=3, [2..31]=0. No output change before the pulse.
- 31 appends of code 2, then a 32nd append, then commit -> o_word_cnt=31, o_overflow=1, no entry [31] write; OP_CLEAR clears o_overflow.
- Backspace on an empty buffer -> wcnt stays 0, no flag. Append 3, backspace, commit -> o_word_cnt=2, [2]=0.
- OP_CLEAR with i_frame_start pulsed 5 cycles later -> o_ready low for 32 cycles; deferred commit gives o_word_cnt=0 and all entries 0 one edge after o_ready rises.
- Append accepted at the same edge as i_frame_start -> that frame shows the old count; the next pulse shows count+1.
- i_rst asserted 10 cycles into a clear -> all outputs 0 and o_ready=1 in the cycle after deassertion.
